// File: rtl/down_timer_if.sv
// down_timer_if: request/status bundle between control logic (master) and down_timer (slave)
// Requests: load, load_value, start, stop, tick, auto_reload. Status: q, busy, paused, tc.
interface down_timer_if #(parameter int WIDTH = 4);
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             stop;
    logic             tick;
    logic             auto_reload;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             paused;
    logic             tc;
    modport master (output load, load_value, start, stop, tick, auto_reload,
                    input  q, busy, paused, tc);
    modport slave  (input  load, load_value, start, stop, tick, auto_reload,
                    output q, busy, paused, tc);
endinterface

// File: rtl/down_timer.sv
// down_timer: loadable, pausable down-counter with one-cycle terminal-count pulse and optional auto-reload
// Ports: clk (rising edge), reset_n (async active-low), bus (down_timer_if.slave: requests in, q/busy/paused/tc out).
module down_timer #(
    parameter int WIDTH = 4
) (
    input logic         clk,
    input logic         reset_n,
    down_timer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, WRAP} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] reload_reg, reload_n, q_n;
    logic             tc_n, active;
    assign active = (state == RUN) || (state == WRAP);
    // Request priority is load > stop > start; counting only advances when no request applies.
    always_comb begin
        state_n  = state;
        q_n      = bus.q;
        reload_n = reload_reg;
        tc_n     = 1'b0;
        if (bus.load) begin
            q_n      = bus.load_value;
            reload_n = bus.load_value;
            state_n  = IDLE;
        end else if (bus.stop)
            state_n = active ? PAUSE : state;
        else if (!active)
            state_n = (bus.start && bus.q != '0) ? RUN : state;
        else if (bus.tick && state == WRAP) begin
            q_n     = reload_reg;
            state_n = RUN;
        end else if (bus.tick && bus.q == WIDTH'(1)) begin
            q_n     = '0;
            tc_n    = 1'b1;
            state_n = (bus.auto_reload && reload_reg != '0) ? WRAP : IDLE;
        end else if (bus.tick && bus.q != '0)
            q_n = bus.q - WIDTH'(1);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            reload_reg <= '0;
            bus.q      <= '0;
            bus.tc     <= 1'b0;
            bus.busy   <= 1'b0;
            bus.paused <= 1'b0;
        end else begin
            state      <= state_n;
            reload_reg <= reload_n;
            bus.q      <= q_n;
            bus.tc     <= tc_n;
            bus.busy   <= (state_n == RUN) || (state_n == WRAP);
            bus.paused <= state_n == PAUSE;
        end
    end
endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed self-checking bench for down_timer with a behavioural reference model
module tb_down_timer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   tc_count = 0;
    bit   alt = 1'b0;
    down_timer_if #(.WIDTH(4)) bus ();
    down_timer #(.WIDTH(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    int m_q, m_rl;
    bit m_run, m_pause, m_wrap, m_tc;
    // Reference model: a count that walks down to zero, a running/paused flag and a pending-reload flag.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q = 0; m_rl = 0; m_run = 0; m_pause = 0; m_wrap = 0; m_tc = 0;
        end else begin
            m_tc = 0;
            if (bus.load) begin
                m_q = int'(bus.load_value); m_rl = m_q;
                m_run = 0; m_pause = 0; m_wrap = 0;
            end else if (bus.stop) begin
                if (m_run) begin m_pause = 1; m_run = 0; m_wrap = 0; end
            end else if (!m_run) begin
                if (bus.start && m_q > 0) begin m_run = 1; m_pause = 0; end
            end else if (bus.tick) begin
                if (m_wrap) begin
                    m_q = m_rl; m_wrap = 0;
                end else if (m_q > 0) begin
                    m_q = m_q - 1;
                    if (m_q == 0) begin
                        m_tc = 1;
                        m_wrap = bus.auto_reload && m_rl > 0;
                        m_run = m_wrap;
                    end
                end
            end
        end
    end
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        chk("model_q", int'(bus.q), m_q);
        chk("model_busy", int'(bus.busy), int'(m_run));
        chk("model_paused", int'(bus.paused), int'(m_pause));
        chk("model_tc", int'(bus.tc), int'(m_tc));
        if (bus.tc) tc_count++;
    end
    task automatic do_load(input logic [3:0] v, input logic with_start);
        bus.load = 1'b1; bus.load_value = v; bus.start = with_start;
        @(negedge clk);
        bus.load = 1'b0; bus.start = 1'b0;
    endtask
    task automatic do_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask
    task automatic period(input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (alt) bus.tick = ~bus.tick;
        end while (!bus.tc && n < lim);
    endtask
    int n, c0;
    initial begin
        bus.load = 0; bus.load_value = 0; bus.start = 0; bus.stop = 0;
        bus.tick = 0; bus.auto_reload = 0;
        repeat (2) @(negedge clk);
        chk("rst_q", int'(bus.q), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_paused", int'(bus.paused), 0);
        chk("rst_tc", int'(bus.tc), 0);
        reset_n = 1'b1;
        @(negedge clk);
        // one-shot count of 5
        do_load(4'd5, 1'b0);
        chk("load5_q", int'(bus.q), 5);
        bus.tick = 1'b1;
        do_start();
        chk("start_busy", int'(bus.busy), 1);
        chk("start_q", int'(bus.q), 5);
        for (int k = 4; k >= 0; k--) begin
            @(negedge clk);
            chk("oneshot_q", int'(bus.q), k);
        end
        chk("oneshot_tc", int'(bus.tc), 1);
        chk("oneshot_busy_fall", int'(bus.busy), 0);
        @(negedge clk);
        chk("oneshot_tc_clear", int'(bus.tc), 0);
        chk("oneshot_hold0", int'(bus.q), 0);
        // auto-reload period N+1
        bus.auto_reload = 1'b1;
        do_load(4'd3, 1'b0);
        do_start();
        period(20, n);
        chk("ar3_sync", int'(n < 20), 1);
        for (int p = 0; p < 3; p++) begin
            period(20, n);
            chk("ar3_period", n, 4);
        end
        // alternating tick doubles the period
        do_load(4'd3, 1'b0);
        do_start();
        alt = 1'b1;
        period(40, n);
        chk("alt_sync", int'(n < 40), 1);
        for (int p = 0; p < 3; p++) begin
            period(40, n);
            chk("alt_period", n, 8);
        end
        alt = 1'b0;
        bus.tick = 1'b1;
        bus.auto_reload = 1'b0;
        // pause and resume
        do_load(4'd10, 1'b0);
        do_start();
        repeat (4) @(negedge clk);
        chk("pre_stop_q", int'(bus.q), 6);
        c0 = tc_count;
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("pause_q", int'(bus.q), 6);
        chk("pause_paused", int'(bus.paused), 1);
        chk("pause_busy", int'(bus.busy), 0);
        bus.stop = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0; bus.start = 1'b0;
        chk("stopstart_paused", int'(bus.paused), 1);
        repeat (4) @(negedge clk);
        chk("pause_hold_q", int'(bus.q), 6);
        do_start();
        chk("resume_busy", int'(bus.busy), 1);
        chk("resume_q", int'(bus.q), 6);
        @(negedge clk);
        chk("resume_dec", int'(bus.q), 5);
        repeat (7) @(negedge clk);
        chk("resume_tc_once", tc_count - c0, 1);
        // load together with start
        do_load(4'd7, 1'b1);
        chk("loadstart_q", int'(bus.q), 7);
        chk("loadstart_busy", int'(bus.busy), 0);
        chk("loadstart_paused", int'(bus.paused), 0);
        // abort a running count
        do_load(4'd9, 1'b0);
        do_start();
        repeat (5) @(negedge clk);
        chk("abort_pre_q", int'(bus.q), 4);
        c0 = tc_count;
        do_load(4'd9, 1'b0);
        chk("abort_q", int'(bus.q), 9);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_tc", int'(bus.tc), 0);
        // asynchronous reset between edges
        do_start();
        repeat (2) @(negedge clk);
        chk("prereset_q", int'(bus.q), 7);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_q", int'(bus.q), 0);
        chk("async_rst_busy", int'(bus.busy), 0);
        chk("async_rst_tc", int'(bus.tc), 0);
        @(negedge clk);
        reset_n = 1'b1;
        chk("abort_no_tc", tc_count - c0, 0);
        // full-scale auto-reload
        bus.auto_reload = 1'b1;
        do_load(4'd15, 1'b0);
        do_start();
        period(40, n);
        chk("ar15_sync", int'(n < 40), 1);
        for (int p = 0; p < 2; p++) begin
            period(40, n);
            chk("ar15_period", n, 16);
        end
        // zero load: start ignored
        do_load(4'd0, 1'b0);
        c0 = tc_count;
        do_start();
        chk("zero_start_busy", int'(bus.busy), 0);
        repeat (3) @(negedge clk);
        chk("zero_no_tc", tc_count - c0, 0);
        chk("zero_q", int'(bus.q), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
